// File: rtl/outbox_uart_tx.sv
// outbox_uart_tx: OUTBOX byte FIFO drained onto a UART tx line as 8N1 frames.
// Define OUTBOX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module outbox_uart_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   wO,
    input  logic [7:0]             data,
    output logic                   outFull,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   tx,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef OUTBOX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    state_t        state_q;
    state_t        state_nx;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    shreg_q;
`ifdef OUTBOX_PARITY_EN
    logic          par_q;
`endif
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          timed;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return p + AW'(1);
    endfunction

`ifdef OUTBOX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    // outFull is judged on the registered count, so a push on a full FIFO is
    // rejected even when the transmitter pops on the same edge.
    assign outFull = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign push    = wO && !outFull;
    assign pop     = (state_q == S_LOAD);
    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (wO && outFull)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            shreg_q <= mem[rd_ptr_q];
`ifdef OUTBOX_PARITY_EN
            par_q   <= even_parity(mem[rd_ptr_q]);
`endif
        end else if (state_q == S_DATA && bit_end) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_nx;
    end

    // Baud counter restarts at every bit boundary; state changes only happen there.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud_q <= '0;
            bit_q  <= '0;
        end else begin
            if (timed && !bit_end)
                baud_q <= baud_q + BW'(1);
            else
                baud_q <= '0;
            if (state_q != S_DATA)
                bit_q <= '0;
            else if (bit_end)
                bit_q <= bit_q + 3'd1;
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE:   if (!empty) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_START;
            S_START:  if (bit_end) state_nx = S_DATA;
            S_DATA: begin
                if (bit_end && bit_q == 3'd7) begin
`ifdef OUTBOX_PARITY_EN
                    state_nx = S_PARITY;
`else
                    state_nx = S_STOP;
`endif
                end
            end
`ifdef OUTBOX_PARITY_EN
            S_PARITY: if (bit_end) state_nx = S_STOP;
`endif
            S_STOP:   if (bit_end) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tx    = 1'b1;
        busy  = 1'b0;
        timed = 1'b0;
        case (state_q)
            S_LOAD: busy = 1'b1;
            S_START: begin
                tx    = 1'b0;
                busy  = 1'b1;
                timed = 1'b1;
            end
            S_DATA: begin
                tx    = shreg_q[0];
                busy  = 1'b1;
                timed = 1'b1;
            end
`ifdef OUTBOX_PARITY_EN
            S_PARITY: begin
                tx    = par_q;
                busy  = 1'b1;
                timed = 1'b1;
            end
`endif
            S_STOP: begin
                busy  = 1'b1;
                timed = 1'b1;
            end
            default: begin
                tx    = 1'b1;
                busy  = 1'b0;
                timed = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_outbox_uart_tx.sv
// tb_outbox_uart_tx: randomized self-checking bench for outbox_uart_tx with a
// frame-decoding monitor and a queue-based model of the byte stream.
module tb_outbox_uart_tx;

    localparam int DEPTH = 8;
    localparam int CPB   = 4;
`ifdef OUTBOX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       wO = 1'b0;
    logic [7:0] data = 8'h00;
    logic       outFull;
    logic       empty;
    logic [3:0] count;
    logic       ovf;
    logic       tx;
    logic       busy;

    outbox_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .wO      (wO),
        .data    (data),
        .outFull (outFull),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_pass   = 0;
    bit         mon_en   = 1'b0;
    int         mon_err  = 0;
    logic [7:0] rx_q[$];
    int         rx_t[$];

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // Serial line monitor: decodes whole frames, checks each bit cell is flat.
    initial begin : monitor
        logic [NB-1:0] bits;
        bit            bad;
        int            t0;
        forever begin
            @(posedge clk); #1;
            if (mon_en && tx === 1'b0) begin
                t0   = cyc;
                bad  = 1'b0;
                bits = '0;
                for (int b = 0; b < NB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (c == 0) bits[b] = tx;
                        else if (tx !== bits[b]) bad = 1'b1;
                        if (b != NB-1 || c != CPB-1) begin
                            @(posedge clk); #1;
                        end
                    end
                end
                if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) bad = 1'b1;
                if (PAR && ((^bits[8:1]) !== bits[9])) bad = 1'b1;
                if (bad) mon_err++;
                rx_q.push_back(bits[8:1]);
                rx_t.push_back(t0);
            end
        end
    end

    function automatic logic exp_tx(input logic [7:0] b, input int k);
        int bi;
        bi = k / CPB;
        if (bi == 0) return 1'b0;
        if (bi <= 8) return b[bi-1];
        if (PAR && bi == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wO = 1'b1;
        data = b;
        tick();
        wO = 1'b0;
    endtask

    task automatic push_ready(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4*FL*DEPTH; i++) begin
            if (!outFull) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) push_byte(b);
    endtask

    task automatic wait_drained(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (empty && !busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        rx_q.delete();
        rx_t.delete();
        mon_err = 0;
    endtask

    task automatic test_reset();
        int n_bad;
        i_rst_n = 1'b0; wO = 1'b0; data = 8'h00;
        repeat (3) tick();
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
        n_checks++; if (outFull !== 1'b0) $display("FAIL reset_full: got %b want 0", outFull); else n_pass++;
        i_rst_n = 1'b1;
        tick();
        // 11 writes: first byte 00 pops after two cycles, so the FIFO saturates and overflows.
        for (int i = 0; i < 11; i++) push_byte(8'(i));
        n_checks++; if (busy !== 1'b1) $display("FAIL midframe_busy: got %b want 1", busy); else n_pass++;
        n_checks++; if (tx !== 1'b0) $display("FAIL midframe_tx: got %b want 0", tx); else n_pass++;
        n_checks++; if (count !== 4'd8) $display("FAIL midframe_count: got %0d want 8", count); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL midframe_ovf: got %b want 1", ovf); else n_pass++;
        #2 i_rst_n = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) $display("FAIL async_rst_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL async_rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL async_rst_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (count !== 4'd0) $display("FAIL async_rst_count: got %0d want 0", count); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL async_rst_ovf: got %b want 0", ovf); else n_pass++;
        tick();
        i_rst_n = 1'b1;
        n_bad = 0;
        for (int i = 0; i < 3*FL; i++) begin
            tick();
            if (tx !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) n_bad++;
        end
        n_checks++; if (n_bad != 0) $display("FAIL post_rst_idle: got %0d non-idle cycles want 0", n_bad); else n_pass++;
    endtask

    task automatic test_frame(input logic [7:0] b);
        logic e;
        do_reset();
        push_byte(b);
        n_checks++; if (count !== 4'd1) $display("FAIL frame_count1: got %0d want 1", count); else n_pass++;
        n_checks++; if (empty !== 1'b0) $display("FAIL frame_empty_fall: got %b want 0", empty); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b1 || tx !== 1'b1) $display("FAIL frame_load: got busy=%b tx=%b want busy=1 tx=1", busy, tx); else n_pass++;
        for (int k = 0; k < FL; k++) begin
            tick();
            e = exp_tx(b, k);
            n_checks++; if (tx !== e) $display("FAIL frame_tx[%0d] byte %h: got %b want %b", k, b, tx, e); else n_pass++;
        end
        tick();
        n_checks++; if (busy !== 1'b0 || tx !== 1'b1 || empty !== 1'b1) $display("FAIL frame_end: got busy=%b tx=%b empty=%b want 0 1 1", busy, tx, empty); else n_pass++;
        n_checks++; if (rx_q.size() != 1 || rx_q[0] !== b) $display("FAIL frame_rx: got %0d bytes first %h want 1 byte %h", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b); else n_pass++;
        n_checks++; if (mon_err != 0) $display("FAIL frame_format: got %0d bad frames want 0", mon_err); else n_pass++;
    endtask

    task automatic test_fill();
        logic [7:0] exp_q[$];
        bit ok;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            push_byte(8'(i));
            exp_q.push_back(8'(i));
            n_checks++; if (outFull !== 1'b0) $display("FAIL fill_full[%0d]: got %b want 0", i, outFull); else n_pass++;
        end
        n_checks++; if (count !== 4'd7) $display("FAIL fill_count: got %0d want 7", count); else n_pass++;
        wait_drained(8*(FL+2)+20, ok);
        n_checks++; if (!ok) $display("FAIL fill_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL fill_rx_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL fill_rx[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        for (int i = 1; i < rx_t.size(); i++) begin
            n_checks++;
            if (rx_t[i] - rx_t[i-1] != FL + 2) $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, rx_t[i] - rx_t[i-1], FL + 2);
            else n_pass++;
        end
        n_checks++; if (mon_err != 0) $display("FAIL fill_format: got %0d bad frames want 0", mon_err); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        bit ok;
        do_reset();
        push_byte(8'hAA);
        exp_q.push_back(8'hAA);
        tick();
        tick();
        n_checks++; if (count !== 4'd0 || tx !== 1'b0) $display("FAIL ovf_setup: got count=%0d tx=%b want 0 0", count, tx); else n_pass++;
        for (int i = 0; i < 9; i++) begin
            push_byte(8'h31 + 8'(i));
            if (i < 8) exp_q.push_back(8'h31 + 8'(i));
            if (i == 7) begin
                n_checks++; if (outFull !== 1'b1) $display("FAIL ovf_full8: got %b want 1", outFull); else n_pass++;
                n_checks++; if (ovf !== 1'b0) $display("FAIL ovf_early: got %b want 0", ovf); else n_pass++;
            end
        end
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b want 1", ovf); else n_pass++;
        n_checks++; if (count !== 4'd8) $display("FAIL ovf_count: got %0d want 8", count); else n_pass++;
        wait_drained(10*(FL+2)+20, ok);
        n_checks++; if (!ok) $display("FAIL ovf_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else n_pass++;
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL ovf_rx_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL ovf_rx[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        bit ok;
        do_reset();
        b = 8'($urandom);
        push_byte(b);
        exp_q.push_back(b);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            push_byte(b);
            exp_q.push_back(b);
        end
        for (int i = 0; i < 2*FL && busy; i++) tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL sim_idle: got busy=%b want 0", busy); else n_pass++;
        n_checks++; if (count !== 4'd3) $display("FAIL sim_count_pre: got %0d want 3", count); else n_pass++;
        tick();
        n_checks++; if (busy !== 1'b1 || tx !== 1'b1) $display("FAIL sim_load: got busy=%b tx=%b want 1 1", busy, tx); else n_pass++;
        b = 8'($urandom);
        exp_q.push_back(b);
        push_byte(b);
        n_checks++; if (count !== 4'd3) $display("FAIL sim_count_post: got %0d want 3", count); else n_pass++;
        n_checks++; if (tx !== 1'b0) $display("FAIL sim_start: got tx=%b want 0", tx); else n_pass++;
        wait_drained(6*(FL+2)+20, ok);
        n_checks++; if (!ok) $display("FAIL sim_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL sim_rx_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL sim_rx[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q[$];
        bit ok;
        bit all_ok;
        bit saw_full;
        do_reset();
        all_ok = 1'b1;
        saw_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outFull) saw_full = 1'b1;
            push_ready(8'h10 + 8'(i), ok);
            if (outFull) saw_full = 1'b1;
            if (!ok) all_ok = 1'b0;
            exp_q.push_back(8'h10 + 8'(i));
        end
        n_checks++; if (!all_ok) $display("FAIL wrap_handshake: got timeout want accepted"); else n_pass++;
        n_checks++; if (saw_full !== 1'b1) $display("FAIL wrap_saw_full: got %b want 1", saw_full); else n_pass++;
        wait_drained(22*(FL+2), ok);
        n_checks++; if (!ok) $display("FAIL wrap_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL wrap_ovf: got %b want 0", ovf); else n_pass++;
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL wrap_rx_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL wrap_rx[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (mon_err != 0) $display("FAIL wrap_format: got %0d bad frames want 0", mon_err); else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        bit ok;
        bit all_ok;
        do_reset();
        all_ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 60)) tick();
            b = 8'($urandom);
            push_ready(b, ok);
            if (!ok) all_ok = 1'b0;
            else exp_q.push_back(b);
        end
        n_checks++; if (!all_ok) $display("FAIL rand_handshake: got timeout want accepted"); else n_pass++;
        wait_drained(26*(FL+2), ok);
        n_checks++; if (!ok) $display("FAIL rand_drain: got timeout want drained"); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL rand_ovf: got %b want 0", ovf); else n_pass++;
        n_checks++; if (rx_q.size() != exp_q.size()) $display("FAIL rand_rx_len: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) begin
            n_checks++;
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) $display("FAIL rand_rx[%0d]: got %h want %h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (mon_err != 0) $display("FAIL rand_format: got %0d bad frames want 0", mon_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_frame(8'hA5);
        test_frame(8'h07);
        test_frame(8'h03);
        test_frame(8'($urandom));
        test_fill();
        test_overflow();
        test_simul_push_pop();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
